// File: rtl/ahb_sram_subordinate_pkg.sv
// Shared AHB-Lite encodings, subordinate FSM states and the byte-lane helper.
package ahb_sram_subordinate_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {IDLE, WAIT, DONE, ERR1, ERR2} sub_state_e;

    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] a);
        case (size)
            HSIZE_BYTE: byte_en = 4'b0001 << a;
            HSIZE_HALF: byte_en = a[1] ? 4'b1100 : 4'b0011;
            default:    byte_en = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ahb_sram_subordinate_if.sv
// AHB-Lite subordinate-side bus bundle; master drives requests, slave returns ready/resp/data.
interface ahb_sram_subordinate_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              HSEL;
    logic [ADDR_W-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [DATA_W-1:0] HWDATA;
    logic              HREADY;
    logic              HREADYOUT;
    logic              HRESP;
    logic [DATA_W-1:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_sram_subordinate_sram_bytewe.sv
// DEPTH x 32 single-clock SRAM with per-byte write enables and a registered read port.
module sram_bytewe #(
    parameter  int DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);
    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/ahb_sram_subordinate.sv
// AHB-Lite SRAM subordinate with programmable wait states and two-cycle ERROR response.
// States: IDLE no data phase | WAIT inserting waits | DONE OKAY completion | ERR1/ERR2 ERROR cycles
module ahb_sram_subordinate
    import ahb_sram_subordinate_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input logic                    clk,
    input logic                    reset,
    ahb_sram_subordinate_if.slave  bus
);
    localparam int              AW         = $clog2(DEPTH);
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(4 * DEPTH);
    localparam logic [3:0]      WAIT_LOAD  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    sub_state_e        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [AW+1:0]     addr_q;
    logic [2:0]        size_q;
    logic              write_q;
    logic [DATA_W-1:0] hold_q;
    logic              fwd_q;
    logic [3:0]        fwd_be_q;
    logic [DATA_W-1:0] fwd_data_q;

    logic              accept, legal, take_new, wr_commit, rd_done;
    logic [AW-1:0]     rd_idx, wr_idx;
    logic [3:0]        wr_be;
    logic [DATA_W-1:0] mem_rdata, rd_word;

    assign accept = bus.HSEL && bus.HREADY &&
                    (bus.HTRANS == HTRANS_NONSEQ || bus.HTRANS == HTRANS_SEQ);
    assign legal  = ({1'b0, bus.HADDR} < ADDR_LIMIT) && (bus.HSIZE <= HSIZE_WORD) &&
                    !(bus.HSIZE == HSIZE_HALF && bus.HADDR[0]) &&
                    !(bus.HSIZE == HSIZE_WORD && bus.HADDR[1:0] != 2'b00);
    assign take_new = accept && (state_q inside {IDLE, DONE, ERR2});

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            WAIT: begin
                if (cnt_q == 4'd0) state_d = DONE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ERR1:    state_d = ERR2;
            default: state_d = IDLE;
        endcase
        if (take_new) begin
            if (!legal) begin
                state_d = ERR1;
            end else if (WAIT_STATES > 0) begin
                state_d = WAIT;
                cnt_d   = WAIT_LOAD;
            end else begin
                state_d = DONE;
            end
        end
    end

    // With no wait states the read must be launched from the live address phase.
    assign wr_commit = (state_q == DONE) && write_q;
    assign rd_done   = (state_q == DONE) && !write_q;
    assign wr_idx    = addr_q[AW+1:2];
    assign wr_be     = byte_en(size_q, addr_q[1:0]);
    assign rd_idx    = take_new ? bus.HADDR[AW+1:2] : addr_q[AW+1:2];

    sram_bytewe #(.DEPTH(DEPTH)) u_sram (
        .clk     (clk),
        .we_i    (wr_commit && !reset),
        .be_i    (wr_be),
        .waddr_i (wr_idx),
        .wdata_i (bus.HWDATA),
        .raddr_i (rd_idx),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        rd_word = mem_rdata;
        if (fwd_q) begin
            for (int b = 0; b < 4; b++) begin
                if (fwd_be_q[b]) rd_word[8*b +: 8] = fwd_data_q[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            hold_q  <= '0;
            fwd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (take_new) write_q <= bus.HWRITE;
            if (rd_done)  hold_q  <= rd_word;
            // The SRAM returns pre-write data when a read launches on the write edge.
            fwd_q <= wr_commit && (wr_idx == rd_idx);
        end
    end

    always_ff @(posedge clk) begin
        if (take_new) begin
            addr_q <= bus.HADDR[AW+1:0];
            size_q <= bus.HSIZE;
        end
        if (wr_commit) begin
            fwd_be_q   <= wr_be;
            fwd_data_q <= bus.HWDATA;
        end
    end

    assign bus.HREADYOUT = !(state_q inside {WAIT, ERR1});
    assign bus.HRESP     = (state_q inside {ERR1, ERR2}) ? HRESP_ERROR : HRESP_OKAY;
    assign bus.HRDATA    = rd_done ? rd_word :
                           (state_q inside {ERR1, ERR2}) ? '0 : hold_q;
endmodule
